// File: rtl/random_row_scheduler_pkg.sv
// rtl/random_row_scheduler_pkg.sv - shared encodings, FSM states and LFSR helpers for the row scheduler
package random_row_scheduler_pkg;

    localparam logic [1:0] SEL_NADA   = 2'd0;
    localparam logic [1:0] SEL_RANDOM = 2'd1;

    localparam logic [7:0] DEFAULT_SEED = 8'h5A;
    // Feedback taps as bit positions of the 8-bit Fibonacci register
    localparam int TAP_A = 7;
    localparam int TAP_B = 5;
    localparam int TAP_C = 4;
    localparam int TAP_D = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMED     = 2'd1,
        EMIT_RAND = 2'd2,
        EMIT_GAP  = 2'd3
    } rsched_state_t;

    function automatic logic [7:0] lfsrNext(input logic [7:0] cur);
        logic fb;
        fb = cur[TAP_A] ^ cur[TAP_B] ^ cur[TAP_C] ^ cur[TAP_D];
        return {cur[6:0], fb};
    endfunction

    // A fully blocked row would be unplayable, so keep the lowest lane open
    function automatic logic [7:0] rowMask(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFE : v;
    endfunction

endpackage

// File: rtl/random_row_scheduler_lfsr8.sv
// rtl/random_row_scheduler_lfsr8.sv - 8-bit Fibonacci LFSR with seed load and step enable
module rsched_lfsr8
    import random_row_scheduler_pkg::*;
#(
    parameter logic [7:0] SEED = DEFAULT_SEED
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       step,
    output logic [7:0] lfsrState,
    output logic [7:0] lfsrNextValue
);

    assign lfsrNextValue = lfsrNext(lfsrState);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsrState <= SEED;
        end else if (load) begin
            lfsrState <= SEED;
        end else if (step) begin
            lfsrState <= lfsrNextValue;
        end
    end

endmodule

// File: rtl/random_row_scheduler.sv
// rtl/random_row_scheduler.sv - interleaves LFSR obstacle rows with blank rows under a valid/ack handshake
module random_row_scheduler
    import random_row_scheduler_pkg::*;
#(
    parameter int         RSCHED_DATAWIDTH = 8,
    parameter logic [7:0] RSCHED_SEED      = DEFAULT_SEED,
    parameter int         RSCHED_GAPWIDTH  = 3
) (
    input  logic                        CC_RSCHED_CLOCK_50,
    input  logic                        CC_RSCHED_RESET_InHigh,
    input  logic                        CC_RSCHED_enable_InHigh,
    input  logic                        CC_RSCHED_clear_InHigh,
    input  logic                        CC_RSCHED_tick_InHigh,
    input  logic                        CC_RSCHED_ack_InHigh,
    input  logic [RSCHED_GAPWIDTH-1:0]  CC_RSCHED_gap_InBUS,
    output logic [1:0]                  CC_RSCHED_select_OutBUS,
    output logic [RSCHED_DATAWIDTH-1:0] CC_RSCHED_random_OutBUS,
    output logic [RSCHED_DATAWIDTH-1:0] CC_RSCHED_nada_OutBUS,
    output logic                        CC_RSCHED_valid_OutHigh,
    output logic                        CC_RSCHED_overrun_OutHigh
);

    rsched_state_t               state;
    rsched_state_t               stateNext;
    logic [RSCHED_GAPWIDTH-1:0]  gapCnt;
    logic [RSCHED_DATAWIDTH-1:0] rowReg;
    logic                        overrunReg;
    logic [7:0]                  lfsrState;
    logic [7:0]                  lfsrNextValue;
    logic                        emitting;
    logic                        randStep;

    assign emitting = (state == EMIT_RAND) || (state == EMIT_GAP);
    assign randStep = !CC_RSCHED_clear_InHigh && CC_RSCHED_enable_InHigh &&
                      (state == ARMED) && CC_RSCHED_tick_InHigh && (gapCnt == '0);

    rsched_lfsr8 #(.SEED(RSCHED_SEED)) u_lfsr (
        .clk           (CC_RSCHED_CLOCK_50),
        .rst           (CC_RSCHED_RESET_InHigh),
        .load          (CC_RSCHED_clear_InHigh),
        .step          (randStep),
        .lfsrState     (lfsrState),
        .lfsrNextValue (lfsrNextValue)
    );

    always_ff @(posedge CC_RSCHED_CLOCK_50 or posedge CC_RSCHED_RESET_InHigh) begin
        if (CC_RSCHED_RESET_InHigh) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        if (CC_RSCHED_clear_InHigh) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE:  if (CC_RSCHED_enable_InHigh) stateNext = ARMED;
                ARMED: begin
                    if (!CC_RSCHED_enable_InHigh) stateNext = IDLE;
                    else if (CC_RSCHED_tick_InHigh)
                        stateNext = (gapCnt == '0) ? EMIT_RAND : EMIT_GAP;
                end
                EMIT_RAND, EMIT_GAP: begin
                    if (CC_RSCHED_ack_InHigh)
                        stateNext = CC_RSCHED_enable_InHigh ? ARMED : IDLE;
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    always_comb begin
        CC_RSCHED_valid_OutHigh = emitting;
        CC_RSCHED_select_OutBUS = (state == EMIT_RAND) ? SEL_RANDOM : SEL_NADA;
    end

    // A tick arriving while a row is still pending is dropped, not queued
    always_ff @(posedge CC_RSCHED_CLOCK_50 or posedge CC_RSCHED_RESET_InHigh) begin
        if (CC_RSCHED_RESET_InHigh) begin
            gapCnt     <= '0;
            rowReg     <= '0;
            overrunReg <= 1'b0;
        end else if (CC_RSCHED_clear_InHigh) begin
            gapCnt     <= '0;
            overrunReg <= 1'b0;
        end else begin
            overrunReg <= emitting && CC_RSCHED_tick_InHigh;
            if (randStep) begin
                rowReg <= rowMask(lfsrNextValue);
            end
            if (CC_RSCHED_ack_InHigh && state == EMIT_RAND) begin
                gapCnt <= CC_RSCHED_gap_InBUS;
            end else if (CC_RSCHED_ack_InHigh && state == EMIT_GAP) begin
                gapCnt <= gapCnt - 1'b1;
            end
        end
    end

    assign CC_RSCHED_random_OutBUS   = rowReg;
    assign CC_RSCHED_nada_OutBUS     = '0;
    assign CC_RSCHED_overrun_OutHigh = overrunReg;

endmodule

// File: tb/tb_random_row_scheduler.sv
// tb/tb_random_row_scheduler.sv - directed self-checking bench for random_row_scheduler
module tb_random_row_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       clear;
    logic       tick;
    logic       ack;
    logic [2:0] gap;

    logic [1:0] sel1, sel2;
    logic [7:0] rnd1, rnd2, nada1, nada2;
    logic       valid1, valid2, ovr1, ovr2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    random_row_scheduler #(.RSCHED_SEED(8'h5A)) dut (
        .CC_RSCHED_CLOCK_50        (clk),
        .CC_RSCHED_RESET_InHigh    (rst),
        .CC_RSCHED_enable_InHigh   (enable),
        .CC_RSCHED_clear_InHigh    (clear),
        .CC_RSCHED_tick_InHigh     (tick),
        .CC_RSCHED_ack_InHigh      (ack),
        .CC_RSCHED_gap_InBUS       (gap),
        .CC_RSCHED_select_OutBUS   (sel1),
        .CC_RSCHED_random_OutBUS   (rnd1),
        .CC_RSCHED_nada_OutBUS     (nada1),
        .CC_RSCHED_valid_OutHigh   (valid1),
        .CC_RSCHED_overrun_OutHigh (ovr1)
    );

    // Seed 7F steps to FF, exercising the open-lane mask on the first row
    random_row_scheduler #(.RSCHED_SEED(8'h7F)) dutMask (
        .CC_RSCHED_CLOCK_50        (clk),
        .CC_RSCHED_RESET_InHigh    (rst),
        .CC_RSCHED_enable_InHigh   (enable),
        .CC_RSCHED_clear_InHigh    (clear),
        .CC_RSCHED_tick_InHigh     (tick),
        .CC_RSCHED_ack_InHigh      (ack),
        .CC_RSCHED_gap_InBUS       (gap),
        .CC_RSCHED_select_OutBUS   (sel2),
        .CC_RSCHED_random_OutBUS   (rnd2),
        .CC_RSCHED_nada_OutBUS     (nada2),
        .CC_RSCHED_valid_OutHigh   (valid2),
        .CC_RSCHED_overrun_OutHigh (ovr2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] muxRow();
        return (sel1 == 2'd1) ? rnd1 : nada1;
    endfunction

    initial begin
        rst = 1'b1; enable = 1'b0; clear = 1'b0; tick = 1'b0; ack = 1'b0; gap = 3'd0;
        #12;
        check("rst_valid",   {7'd0, valid1}, 8'h00);
        check("rst_select",  {6'd0, sel1},   8'h00);
        check("rst_random",  rnd1,           8'h00);
        check("rst_nada",    nada1,          8'h00);
        check("rst_overrun", {7'd0, ovr1},   8'h00);
        check("rst_random2", rnd2,           8'h00);
        rst = 1'b0;
        enable = 1'b1;
        step();

        // gap=0: back-to-back random rows
        tick = 1'b1;
        check("pre_tick_valid", {7'd0, valid1}, 8'h00);
        step(); tick = 1'b0;
        check("row1_valid",  {7'd0, valid1}, 8'h01);
        check("row1_select", {6'd0, sel1},   8'h01);
        check("row1_random", rnd1,           8'hB4);
        check("mask_random", rnd2,           8'hFE);
        check("mask_select", {6'd0, sel2},   8'h01);
        ack = 1'b1; step(); ack = 1'b0;
        check("row1_acked",  {7'd0, valid1}, 8'h00);
        tick = 1'b1; step(); tick = 1'b0;
        check("row2_random", rnd1,           8'h69);
        check("row2_select", {6'd0, sel1},   8'h01);
        check("row2_ovr",    {7'd0, ovr1},   8'h00);
        ack = 1'b1; step(); ack = 1'b0;

        // restart, then gap=2 pattern R,N,N,R
        clear = 1'b1; step(); clear = 1'b0;
        check("clear_valid", {7'd0, valid1}, 8'h00);
        step();
        gap = 3'd2;
        tick = 1'b1; step(); tick = 1'b0;
        check("g0_select", {6'd0, sel1}, 8'h01);
        check("g0_row",    muxRow(),     8'hB4);
        ack = 1'b1; step(); ack = 1'b0;
        tick = 1'b1; step(); tick = 1'b0;
        check("g1_select", {6'd0, sel1},   8'h00);
        check("g1_valid",  {7'd0, valid1}, 8'h01);
        check("g1_row",    muxRow(),       8'h00);
        ack = 1'b1; step(); ack = 1'b0;
        tick = 1'b1; step(); tick = 1'b0;
        check("g2_select", {6'd0, sel1}, 8'h00);
        check("g2_row",    muxRow(),     8'h00);
        ack = 1'b1; step(); ack = 1'b0;
        tick = 1'b1; step(); tick = 1'b0;
        check("g3_select", {6'd0, sel1}, 8'h01);
        check("g3_row",    muxRow(),     8'h69);
        ack = 1'b1; step(); ack = 1'b0;

        // overrun: second tick with no ack (gap counter reloaded to 2)
        tick = 1'b1; step();
        check("ov_pre", {7'd0, ovr1}, 8'h00);
        step(); tick = 1'b0;
        check("ov_pulse",  {7'd0, ovr1},   8'h01);
        check("ov_valid",  {7'd0, valid1}, 8'h01);
        check("ov_select", {6'd0, sel1},   8'h00);
        step();
        check("ov_end",    {7'd0, ovr1},   8'h00);
        check("ov_held",   {7'd0, valid1}, 8'h01);
        ack = 1'b1; step(); ack = 1'b0;
        check("ov_acked",  {7'd0, valid1}, 8'h00);

        // ack and tick together: row completes, tick dropped
        tick = 1'b1; step();
        ack = 1'b1; step(); ack = 1'b0; tick = 1'b0;
        check("at_valid", {7'd0, valid1}, 8'h00);
        check("at_ovr",   {7'd0, ovr1},   8'h01);
        step();
        check("at_ovr_end", {7'd0, ovr1}, 8'h00);

        // ack while idle-handshake is ignored
        ack = 1'b1; step(); ack = 1'b0;
        check("stray_ack", {7'd0, valid1}, 8'h00);

        // clear together with ack in EMIT_RAND
        gap = 3'd0;
        tick = 1'b1; step(); tick = 1'b0;
        check("pre_clear_row", rnd1, 8'hD2);
        clear = 1'b1; ack = 1'b1; step(); clear = 1'b0; ack = 1'b0;
        check("clr_valid",  {7'd0, valid1}, 8'h00);
        check("clr_select", {6'd0, sel1},   8'h00);
        step();
        tick = 1'b1; step(); tick = 1'b0;
        check("clr_restart_row", rnd1, 8'hB4);
        ack = 1'b1; step(); ack = 1'b0;

        // enable low mid-emission finishes the row then parks in IDLE
        tick = 1'b1; step(); tick = 1'b0;
        check("en_row", rnd1, 8'h69);
        enable = 1'b0; step();
        check("en_hold", {7'd0, valid1}, 8'h01);
        ack = 1'b1; step(); ack = 1'b0;
        tick = 1'b1; step(); tick = 1'b0;
        check("en_idle_tick", {7'd0, valid1}, 8'h00);
        enable = 1'b1; step();
        tick = 1'b1; step(); tick = 1'b0;
        check("en_retained_lfsr", rnd1, 8'hD2);
        ack = 1'b1; step(); ack = 1'b0;

        // async reset in the middle of a gap row
        gap = 3'd1;
        tick = 1'b1; step(); tick = 1'b0;
        check("pre_rst_row", rnd1, 8'hA4);
        ack = 1'b1; step(); ack = 1'b0;
        tick = 1'b1; step(); tick = 1'b0;
        check("gap_before_rst", {7'd0, valid1}, 8'h01);
        #2 rst = 1'b1;
        #1;
        check("arst_valid",  {7'd0, valid1}, 8'h00);
        check("arst_select", {6'd0, sel1},   8'h00);
        check("arst_random", rnd1,           8'h00);
        #1 rst = 1'b0;
        gap = 3'd0;
        step();
        tick = 1'b1; step(); tick = 1'b0;
        check("arst_seed_row", rnd1, 8'hB4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
